// File: rtl/mem_dump_arbiter.sv
// Shares the single-port data RAM between the CPU MEM stage and a word-by-word dump engine.
// The CPU is frozen through MemStall while the dump streams every word out over valid/ready.
module mem_dump_arbiter #(
  parameter int DEPTH = 512,
  parameter int IDX_W = 9
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic [31:0]      CpuAddr_M,
  input  logic             CpuReadEN_M,
  input  logic             CpuWriteEN_M,
  input  logic [31:0]      CpuWriteData_M,
  output logic [31:0]      CpuReadData_M,
  output logic             MemStall,
  output logic [IDX_W-1:0] RamIndex,
  output logic             RamWriteEN,
  output logic [31:0]      RamWriteData,
  input  logic [31:0]      RamReadData,
  input  logic             DumpReq,
  output logic             DumpValid,
  input  logic             DumpReady,
  output logic [31:0]      DumpData,
  output logic [IDX_W-1:0] DumpIndex,
  output logic             DumpDone
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DRAIN = 2'd1;
  localparam logic [1:0] S_DUMP  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  // Pointer is one bit wider than the index so "all words loaded" differs from word 0.
  localparam logic [IDX_W:0] PTR_END = (IDX_W+1)'(DEPTH);
  localparam logic [IDX_W:0] PTR_ONE = (IDX_W+1)'(1);

  logic [1:0]       r_state;
  logic [IDX_W:0]   r_ptr;
  logic             r_dump_vld;
  logic [31:0]      r_dump_dat;
  logic [IDX_W-1:0] r_dump_idx;
  logic [31:0]      r_cpu_rd;

  logic w_cpu_owns;
  logic w_pop;
  logic w_load;
  logic w_last;
  logic w_unused_addr_bits;

  assign w_unused_addr_bits = ^{CpuAddr_M[31:IDX_W+2], CpuAddr_M[1:0]};

  assign w_cpu_owns = (r_state == S_IDLE) || (r_state == S_DRAIN);
  assign w_pop      = r_dump_vld && DumpReady;
  assign w_last     = (r_ptr == PTR_END);
  assign w_load     = (r_state == S_DUMP) && (!r_dump_vld || DumpReady) && !w_last;

  always_comb begin
    RamIndex      = w_cpu_owns ? CpuAddr_M[IDX_W+1:2] : r_ptr[IDX_W-1:0];
    RamWriteEN    = w_cpu_owns && CpuWriteEN_M;
    RamWriteData  = CpuWriteData_M;
    CpuReadData_M = w_cpu_owns ? RamReadData : r_cpu_rd;
    MemStall      = (r_state != S_IDLE);
    DumpDone      = (r_state == S_DONE);
    DumpValid     = r_dump_vld;
    DumpData      = r_dump_dat;
    DumpIndex     = r_dump_idx;
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      r_state    <= S_IDLE;
      r_ptr      <= '0;
      r_dump_vld <= 1'b0;
      r_dump_dat <= '0;
      r_dump_idx <= '0;
      r_cpu_rd   <= '0;
    end else begin
      // Keeps the last completed load visible to the frozen pipeline.
      if (w_cpu_owns && CpuReadEN_M) begin
        r_cpu_rd <= RamReadData;
      end
      case (r_state)
        S_IDLE: begin
          if (DumpReq) begin
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          r_state <= S_DUMP;
        end
        S_DUMP: begin
          if (w_pop && w_last) begin
            r_dump_vld <= 1'b0;
            r_state    <= S_DONE;
          end else if (w_load) begin
            r_dump_dat <= RamReadData;
            r_dump_idx <= r_ptr[IDX_W-1:0];
            r_dump_vld <= 1'b1;
            r_ptr      <= r_ptr + PTR_ONE;
          end
        end
        default: begin
          r_ptr   <= '0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
